// File: rtl/cnt_match_driver_if.sv
// cnt_match_driver_if: controller handshake, run config/results and match-block pins (C, P_0, Z_in) of the driver
interface cnt_match_driver_if #(parameter int NPULSE_W = 16);
  logic start, abort, Z_in, P_0, busy, done, aborted;
  logic [16:0] cfg_match, C;
  logic [NPULSE_W-1:0] cfg_pulses, hit_count, first_hit;
  modport master (output start, abort, cfg_match, cfg_pulses, Z_in,
                  input P_0, C, busy, done, aborted, hit_count, first_hit);
  modport slave (input start, abort, cfg_match, cfg_pulses, Z_in,
                 output P_0, C, busy, done, aborted, hit_count, first_hit);
endinterface

// File: rtl/cnt_match_driver.sv
// cnt_match_driver: loads C, settles, pulses P_0 cfg_pulses times sampling Z; ports CK/RST plus bus (start/abort/cfg in, P_0/C/busy/done/aborted/hit_count/first_hit out)
module cnt_match_driver #(
  parameter int SETTLE = 2,
  parameter int NPULSE_W = 16
) (
  input logic CK,
  input logic RST,
  cnt_match_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [16:0] c;
  logic [NPULSE_W-1:0] remaining, hit_count, first_hit, run_idx;
  logic [3:0] settle_cnt;
  logic aborted;
  wire accept = state == IDLE && bus.start && !bus.abort;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = accept ? LOAD : IDLE;
      LOAD: state_n = bus.abort ? IDLE :
                      settle_cnt == 4'(SETTLE - 1) ? (remaining != '0 ? RUN : DONE) : LOAD;
      RUN:  state_n = bus.abort ? IDLE : remaining == NPULSE_W'(1) ? DONE : RUN;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      c <= '0;
      remaining <= '0;
      hit_count <= '0;
      first_hit <= '1;
      run_idx <= '0;
      settle_cnt <= '0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        c <= bus.cfg_match;
        remaining <= bus.cfg_pulses;
        hit_count <= '0;
        first_hit <= '1;
        run_idx <= '0;
        settle_cnt <= '0;
        aborted <= 1'b0;
      end
      if (bus.abort && (state == LOAD || state == RUN)) aborted <= 1'b1;
      if (state == LOAD) settle_cnt <= settle_cnt + 4'd1;
      if (state == RUN && !bus.abort) begin
        if (bus.Z_in && hit_count != '1) hit_count <= hit_count + 1'b1;
        if (bus.Z_in && first_hit == '1) first_hit <= run_idx;
        run_idx <= run_idx + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end
  assign bus.P_0 = state == RUN;
  assign bus.busy = state == LOAD || state == RUN;
  assign bus.done = state == DONE;
  assign bus.C = c;
  assign bus.aborted = aborted;
  assign bus.hit_count = hit_count;
  assign bus.first_hit = first_hit;
endmodule

// File: tb/tb_cnt_match_driver.sv
// tb_cnt_match_driver: directed checks of cnt_match_driver (reset, normal, abort, zero pulses, busy start, saturation)
module tb_cnt_match_driver;
  logic CK = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;
  cnt_match_driver_if #(.NPULSE_W(16)) a();
  cnt_match_driver_if #(.NPULSE_W(4)) b();
  cnt_match_driver #(.SETTLE(2), .NPULSE_W(16)) dut_a (.CK(CK), .RST(RST), .bus(a.slave));
  cnt_match_driver #(.SETTLE(2), .NPULSE_W(4)) dut_b (.CK(CK), .RST(RST), .bus(b.slave));
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic run_a(input logic [16:0] m, input logic [15:0] n, input logic [31:0] zm,
                       input bit rebusy, output int first_p, output int np, output int done_at);
    first_p = -1;
    np = 0;
    done_at = -1;
    @(negedge CK);
    a.start = 1'b1;
    a.cfg_match = m;
    a.cfg_pulses = n;
    a.Z_in = 1'b1;
    for (int j = 1; j < 100 && done_at < 0; j++) begin
      @(negedge CK);
      a.start = rebusy && j == 2;
      a.cfg_match = (rebusy && j == 2) ? ~m : m;
      a.cfg_pulses = (rebusy && j == 2) ? n + 16'd3 : n;
      if (j == 1) begin
        chk("busy_after_start", a.busy, 1);
        chk("c_after_start", a.C, m);
      end
      if (a.done) begin
        done_at = j;
        chk("busy_at_done", a.busy, 0);
      end
      if (a.P_0) begin
        if (first_p < 0) first_p = j;
        a.Z_in = zm[np];
        np++;
      end else a.Z_in = 1'b1;
    end
    @(negedge CK);
    chk("done_one_cycle", a.done, 0);
  endtask
  initial begin
    int fp, np, da, d, pb, dn;
    a.start = 0; a.abort = 0; a.cfg_match = '0; a.cfg_pulses = '0; a.Z_in = 0;
    b.start = 0; b.abort = 0; b.cfg_match = '0; b.cfg_pulses = '0; b.Z_in = 0;
    repeat (2) @(negedge CK);
    chk("rst_p0", a.P_0, 0);
    chk("rst_c", a.C, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_aborted", a.aborted, 0);
    chk("rst_hit", a.hit_count, 0);
    chk("rst_first", a.first_hit, 32'hFFFF);
    chk("rst_first_b", b.first_hit, 32'hF);
    RST = 1'b0;
    @(negedge CK);
    a.start = 1'b1; a.cfg_match = 17'h1F0F0; a.cfg_pulses = 16'd20; a.Z_in = 1'b0;
    np = 0;
    for (int j = 1; j < 50; j++) begin
      @(negedge CK);
      a.start = 1'b0;
      if (a.P_0) begin
        if (np == 5) break;
        a.Z_in = np == 3;
        np++;
      end
    end
    chk("pre_reset_idx", np, 5);
    chk("pre_reset_first", a.first_hit, 3);
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_p0", a.P_0, 0);
    chk("mid_rst_busy", a.busy, 0);
    chk("mid_rst_done", a.done, 0);
    chk("mid_rst_c", a.C, 0);
    chk("mid_rst_first", a.first_hit, 32'hFFFF);
    chk("mid_rst_hit", a.hit_count, 0);
    d = 0;
    repeat (3) begin
      @(negedge CK);
      d |= a.done;
    end
    RST = 1'b0;
    chk("no_done_in_rst", d, 0);
    run_a(17'h00001, 16'd20, 32'h88, 0, fp, np, da);
    chk("norm_first_p0", fp, 3);
    chk("norm_npulse", np, 20);
    chk("norm_done_at", da, 23);
    chk("norm_hit", a.hit_count, 2);
    chk("norm_first_hit", a.first_hit, 3);
    chk("norm_c_held", a.C, 17'h00001);
    @(negedge CK);
    a.start = 1'b1; a.cfg_match = 17'h0AAAA; a.cfg_pulses = 16'd10; a.Z_in = 1'b0;
    np = 0;
    for (int j = 1; j < 50; j++) begin
      @(negedge CK);
      a.start = 1'b0;
      if (a.P_0) begin
        a.Z_in = np == 1;
        if (np == 4) begin
          a.abort = 1'b1;
          break;
        end
        np++;
      end
    end
    @(negedge CK);
    a.abort = 1'b0;
    chk("abort_p0", a.P_0, 0);
    chk("abort_flag", a.aborted, 1);
    chk("abort_busy", a.busy, 0);
    chk("abort_hit", a.hit_count, 1);
    chk("abort_first", a.first_hit, 1);
    d = a.done;
    repeat (3) begin
      @(negedge CK);
      d |= a.done;
    end
    chk("abort_no_done", d, 0);
    run_a(17'h12345, 16'd0, 32'h0, 0, fp, np, da);
    chk("zero_aborted_clr", a.aborted, 0);
    chk("zero_first_p0", fp, -1);
    chk("zero_npulse", np, 0);
    chk("zero_done_at", da, 3);
    chk("zero_hit", a.hit_count, 0);
    chk("zero_first", a.first_hit, 32'hFFFF);
    run_a(17'h1ABCD, 16'd5, 32'h5, 1, fp, np, da);
    chk("busy_npulse", np, 5);
    chk("busy_done_at", da, 8);
    chk("busy_hit", a.hit_count, 2);
    chk("busy_first", a.first_hit, 0);
    chk("busy_c", a.C, 17'h1ABCD);
    @(negedge CK);
    b.start = 1'b1; b.abort = 1'b1; b.cfg_pulses = 4'd15; b.Z_in = 1'b1;
    @(negedge CK);
    b.start = 1'b0; b.abort = 1'b0;
    chk("start_abort_ignored", b.busy, 0);
    @(negedge CK);
    b.start = 1'b1;
    pb = 0;
    dn = 0;
    for (int j = 1; j < 60 && dn == 0; j++) begin
      @(negedge CK);
      b.start = 1'b0;
      if (b.P_0) pb++;
      if (b.done) dn = 1;
    end
    chk("sat_npulse", pb, 15);
    chk("sat_done", dn, 1);
    chk("sat_hit", b.hit_count, 4'hF);
    chk("sat_first", b.first_hit, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
